// File: rtl/rot_pkg.sv
// rot_pkg: shared definitions for the variable-amount rotate unit.
//   - rot_state_e : FSM states (IDLE, ROT, DONE)
//   - DEF_WIDTH / DEF_STEP : default data width and positions rotated per cycle
//   - amt_width() : width of a rotate amount for a given data width
package rot_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } rot_state_e;

  // Number of bits needed to hold an amount 0..width-1.
  function automatic int amt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/rotl_step.sv
// rotl_step: combinational rotate of one word by a small amount.
// Optional feature macro: ROTL_DIR_SEL_EN (adds the dir input, 1 = rotate right).
// Ports:
//   d   : word to rotate
//   amt : rotate amount, 0..WIDTH (one bit wider than a normal amount)
//   dir : (ROTL_DIR_SEL_EN only) 0 = left, 1 = right
//   q   : rotated word
module rotl_step
  import rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = amt_width(DEF_WIDTH) + 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
`ifdef ROTL_DIR_SEL_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] q
);

  localparam logic [AMT_W-1:0] W_V = AMT_W'(WIDTH);

  // A shift by WIDTH yields zero, so amt=0 needs no special case.
  function automatic logic [WIDTH-1:0] rotl_f(input logic [WIDTH-1:0] v,
                                              input logic [AMT_W-1:0] a);
    return (v << a) | (v >> (W_V - a));
  endfunction

`ifdef ROTL_DIR_SEL_EN
  function automatic logic [WIDTH-1:0] rotr_f(input logic [WIDTH-1:0] v,
                                              input logic [AMT_W-1:0] a);
    return (v >> a) | (v << (W_V - a));
  endfunction
`endif

  // Rotate the input word by the step amount in the selected direction.
  always_comb begin
    q = {WIDTH{1'b0}};
`ifdef ROTL_DIR_SEL_EN
    if (dir == 1'b1) begin
      q = rotr_f(d, amt);
    end else begin
      q = rotl_f(d, amt);
    end
`else
    q = rotl_f(d, amt);
`endif
  end

endmodule

// File: rtl/rotl_seq.sv
// rotl_seq: multi-cycle variable-amount rotate unit (at most STEP positions
// per clock) with valid/ready handshakes on input and output.
// Optional feature macro: ROTL_DIR_SEL_EN (adds in_dir, 1 = rotate right).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : request present           in_ready  : idle, can accept
//   in_data   : word to rotate            in_amt    : amount 0..WIDTH-1
//   in_dir    : (ROTL_DIR_SEL_EN only) 0 = left, 1 = right
//   out_valid : result available          out_ready : consumer takes result
//   out_data  : work register (the result while out_valid is high)
module rotl_seq
  import rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [amt_width(WIDTH)-1:0]  in_amt,
`ifdef ROTL_DIR_SEL_EN
  input  logic                         in_dir,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data
);

  localparam int AW = amt_width(WIDTH);
  // One extra bit so STEP == WIDTH is representable.
  localparam logic [AW:0] STEP_V = (AW + 1)'(STEP);

  rot_state_e       state_r;
  logic [WIDTH-1:0] work_r;
  logic [AW-1:0]    rem_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [AW:0]      rem_ext_s;
  logic [AW:0]      step_amt_s;
  logic             last_step_s;
  logic [WIDTH-1:0] rot_s;
`ifdef ROTL_DIR_SEL_EN
  logic             dir_r;
`endif

  // Per-cycle rotate amount: min(rem, STEP); last step when rem fits in one.
  always_comb begin
    rem_ext_s   = {1'b0, rem_r};
    step_amt_s  = rem_ext_s;
    last_step_s = 1'b0;
    if (rem_ext_s > STEP_V) begin
      step_amt_s  = STEP_V;
      last_step_s = 1'b0;
    end else begin
      step_amt_s  = rem_ext_s;
      last_step_s = 1'b1;
    end
  end

  rotl_step #(
    .WIDTH (WIDTH),
    .AMT_W (AW + 1)
  ) u_step (
    .d   (work_r),
    .amt (step_amt_s),
`ifdef ROTL_DIR_SEL_EN
    .dir (dir_r),
`endif
    .q   (rot_s)
  );

  // Control FSM, work register, remaining-amount counter and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      work_r      <= {WIDTH{1'b0}};
      rem_r       <= {AW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef ROTL_DIR_SEL_EN
      dir_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= in_data;
            rem_r      <= in_amt;
`ifdef ROTL_DIR_SEL_EN
            dir_r      <= in_dir;
`endif
            in_ready_r <= 1'b0;
            state_r    <= ROT;
          end
        end
        ROT: begin
          // At least one ROT edge always happens, even for amt=0.
          work_r <= rot_s;
          rem_r  <= rem_r - step_amt_s[AW-1:0];
          if (last_step_s) begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = work_r;

endmodule

// File: doc/rotl_seq.md
# rotl_seq

Multi-cycle, variable-amount rotate-left unit for the SHA-256 datapath.
- Accepts a 32-bit word and a rotate amount over a valid/ready handshake.
- Rotates by at most STEP bit positions per clock, then presents the result on a second valid/ready handshake.
- Complements the fixed right-rotate blocks: amounts decided at runtime are handled here, trading latency for area in the nonce/scheduler control paths.

## Interface
- WIDTH, 32: data word width; must be a power of two.
- STEP, 4: maximum rotate positions applied per cycle; 1 ≤ STEP ≤ WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  $clog2(WIDTH)  rotate amount, 0..WIDTH-1.
- in_dir  input  1  present only with ROTL_DIR_SEL_EN: 0 = rotate left, 1 = rotate right.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  rotated word.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch in_data into the work register and in_amt into the remaining counter, then go to ROT.
  - ROT: each edge rotates the work register by min(rem, STEP) and subtracts that from rem. When rem ≤ STEP at the edge, go to DONE. ROT always lasts at least one edge, so amt=0 spends one ROT cycle rotating by 0.
  - DONE: out_valid=1 and out_data = work register. On out_ready, go to IDLE.
- No request is accepted in ROT or DONE. in_valid is ignored there.
- out_data equals the work register in every state. It is stable and valid while out_valid=1.
- Amount arithmetic is unsigned and uses $clog2(WIDTH) bits. Amounts are inherently modulo WIDTH.
- The result is bit-exact with {d,d} >> (WIDTH-amt) taking the low WIDTH bits (i.e. rotl(d, amt)).

## Timing
- Reset (async, immediate): state=IDLE, work register=0, rem=0. So in_ready=1, out_valid=0, out_data=0.
- Latency from the accept edge to out_valid high: max(1, ceil(amt/STEP)) cycles.
  - WIDTH=32, STEP=4: amt=0 → 1, amt=4 → 1, amt=9 → 3, amt=31 → 8.
- Out→In turnaround: the DONE handshake edge returns to IDLE. The next accept can occur on the following edge, so there is a minimum one-cycle gap.
- Backpressure: DONE holds indefinitely with out_data unchanged until out_ready=1.
- Reset asserted mid-ROT or in DONE: the result is discarded, outputs drop to reset values asynchronously, and there is no spurious out_valid after release.
- in_valid held high through a transaction: exactly one transaction is taken per IDLE visit.

## Configuration
- ROTL_DIR_SEL_EN defined:
  - in_dir exists and is latched at accept.
  - When in_dir=1, each ROT step rotates right by min(rem, STEP) instead of left. Latency is identical.
- Undefined: no in_dir port; always rotate left.

## Structure
- Shared package rot_pkg holds:
  - the state enum (IDLE, ROT, DONE);
  - the default WIDTH/STEP constants;
  - an amount-width localparam helper ($clog2(WIDTH)).
- One sub-module, rotl_step: a combinational rotate of the work register by a 0..STEP amount (and a direction, under the macro). It is instantiated once; the FSM and counter live in rotl_seq.

## Test plan
- Post-reset check: in_ready=1, out_valid=0, out_data=0. Then in_data=0x80000001, amt=1 → out_data=0x00000003, out_valid high 1 cycle after accept.
- in_data=0x12345678, amt=8, STEP=4 → out_valid after 2 cycles, out_data=0x34567812.
- in_data=0xDEADBEEF, amt=0 → out_valid after 1 cycle, out_data=0xDEADBEEF. in_ready=0 throughout ROT/DONE.
- amt=31 on 0x00000001 with out_ready held low for 5 cycles → out_data=0x80000000 held stable and out_valid held high. Completes on the out_ready edge; in_ready returns the next cycle.
- Reset pulsed two cycles into an amt=20 rotation → out_valid never rises, state is IDLE. A following amt=1 request completes correctly.
- With ROTL_DIR_SEL_EN: in_data=0x12345678, amt=4, in_dir=1 → out_data=0x81234567 after 1 cycle.
